uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader_pkg.sv | 16 +
 rtl/loader_timeout.sv | 35 +++
 rtl/uart_loader.sv | 159 +++++++++++++++
 tb/tb_uart_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared state encoding and frame constants for the UART boot loader
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [7:0] START_BYTE = 8'hA5;

endpackage

// File: rtl/loader_timeout.sv
// rtl/loader_timeout.sv - inter-byte idle counter; flags expiry after TIMEOUT_CYCLES quiet cycles
module loader_timeout #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic reload,
  output logic expired
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Saturates at the limit so expiry stays asserted until the FSM leaves the frame.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || reload) begin
      cnt_d = 32'd0;
    end else if (cnt_q != TIMEOUT_CYCLES) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == TIMEOUT_CYCLES);

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - framed UART image loader writing little-endian words to instruction memory
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [15:0] MAX_WORDS      = 16'd1024,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done_sig,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  loader_state_t state_q;
  logic [7:0]    len_lo_q;
  logic [15:0]   len_q;
  logic [15:0]   word_cnt_q;
  logic [1:0]    byte_idx_q;
  logic [23:0]   word_q;
  logic [7:0]    csum_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          cpu_hold_q;
  logic          load_done_q;
  logic          load_err_q;

  logic          in_frame;
  logic          expired;
  logic [15:0]   len_rx;

  assign in_frame = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA)   || (state_q == CSUM);
  assign len_rx   = {rx_data, len_lo_q};

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (in_frame),
    .reload (rx_done_sig),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_lo_q    <= 8'd0;
      len_q       <= 16'd0;
      word_cnt_q  <= 16'd0;
      byte_idx_q  <= 2'd0;
      word_q      <= 24'd0;
      csum_q      <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 32'd0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (mem_we_q) begin
        mem_addr_q <= mem_addr_q + 32'd4;
      end

      // Inside a frame an arriving byte always beats a simultaneous timeout expiry.
      if (in_frame && !rx_done_sig && expired) begin
        state_q    <= ERR;
        load_err_q <= 1'b1;
        cpu_hold_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE, DONE, ERR: begin
            if (rx_done_sig && rx_data == START_BYTE) begin
              state_q     <= LEN_LO;
              cpu_hold_q  <= 1'b1;
              load_done_q <= 1'b0;
              load_err_q  <= 1'b0;
              csum_q      <= 8'd0;
              byte_idx_q  <= 2'd0;
              word_cnt_q  <= 16'd0;
              mem_addr_q  <= BASE_ADDR;
            end
          end
          LEN_LO: begin
            if (rx_done_sig) begin
              len_lo_q <= rx_data;
              csum_q   <= csum_q ^ rx_data;
              state_q  <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (rx_done_sig) begin
              len_q  <= len_rx;
              csum_q <= csum_q ^ rx_data;
              if (len_rx == 16'd0) begin
                state_q <= CSUM;
              end else if (len_rx > MAX_WORDS) begin
                state_q    <= ERR;
                load_err_q <= 1'b1;
              end else begin
                state_q <= DATA;
              end
            end
          end
          DATA: begin
            if (rx_done_sig) begin
              csum_q     <= csum_q ^ rx_data;
              byte_idx_q <= byte_idx_q + 2'd1;
              case (byte_idx_q)
                2'd0: word_q[7:0]   <= rx_data;
                2'd1: word_q[15:8]  <= rx_data;
                2'd2: word_q[23:16] <= rx_data;
                default: begin
                  mem_wdata_q <= {rx_data, word_q};
                  mem_we_q    <= 1'b1;
                  word_cnt_q  <= word_cnt_q + 16'd1;
                  if (word_cnt_q + 16'd1 == len_q) begin
                    state_q <= CSUM;
                  end
                end
              endcase
            end
          end
          CSUM: begin
            if (rx_done_sig) begin
              if (rx_data == csum_q) begin
                state_q     <= DONE;
                load_done_q <= 1'b1;
                cpu_hold_q  <= 1'b0;
              end else begin
                state_q    <= ERR;
                load_err_q <= 1'b1;
                cpu_hold_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - scoreboard bench for uart_loader frame handling, errors and reset
module tb_uart_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done_sig;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb[$];
  logic [7:0]  fq[$];
  logic        prev_we = 1'b0;

  uart_loader #(
    .BASE_ADDR     (32'h0000_0000),
    .MAX_WORDS     (16'd4),
    .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_done_sig(rx_done_sig),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [63:0] exp;
    if (rst_n) begin
      if (mem_we && prev_we) begin
        checks++;
        errors++;
        $display("FAIL we_consecutive mem_we high two cycles at addr %h", mem_addr);
      end
      if (mem_we) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr %h data %h, expected no write", mem_addr, mem_wdata);
        end else begin
          exp = sb.pop_front();
          if ({mem_addr, mem_wdata} !== exp) begin
            errors++;
            $display("FAIL write got addr %h data %h, expected addr %h data %h",
                     mem_addr, mem_wdata, exp[63:32], exp[31:0]);
          end
        end
      end
    end
    prev_we = mem_we;
  end

  // Called at a falling edge; leaves rx_done_sig low after `gap` idle cycles (gap 0 = back-to-back).
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data     = b;
    rx_done_sig = 1'b1;
    @(negedge clk);
    rx_done_sig = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int gap);
    foreach (fq[i]) send_byte(fq[i], gap);
    fq.delete();
  endtask

  task automatic add_csum(input logic [7:0] flip);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < fq.size(); i++) x ^= fq[i];
    fq.push_back(x ^ flip);
  endtask

  task automatic expect_status(input string name, input logic done_e, input logic err_e, input logic hold_e);
    checks++;
    if ({load_done, load_err, cpu_hold} !== {done_e, err_e, hold_e}) begin
      errors++;
      $display("FAIL %s done/err/hold got %b%b%b expected %b%b%b",
               name, load_done, load_err, cpu_hold, done_e, err_e, hold_e);
    end
  endtask

  task automatic expect_drained(input string name);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_writes_missing got %0d pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_done_sig = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mem got we %b addr %h data %h expected 0/0/0", mem_we, mem_addr, mem_wdata);
    end
    expect_status("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    fq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    add_csum(8'h00);
    sb.push_back({32'h0, 32'h4433_2211});
    sb.push_back({32'h4, 32'h8877_6655});
    send_frame(1);
    expect_drained("good");
    expect_status("good", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bad_csum();
    fq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    add_csum(8'h01);
    sb.push_back({32'h0, 32'h4433_2211});
    sb.push_back({32'h4, 32'h8877_6655});
    send_frame(2);
    expect_drained("bad_csum");
    expect_status("bad_csum", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_zero_len();
    // Gaps just under the timeout must not trip it.
    fq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(95);
    expect_drained("zero_len");
    expect_status("zero_len", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int waited;
    fq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_frame(0);
    repeat (90) @(negedge clk);
    expect_status("timeout_early", 1'b0, 1'b0, 1'b1);
    waited = 0;
    while (!load_err && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    expect_status("timeout", 1'b0, 1'b1, 1'b1);
    expect_drained("timeout");
    fq = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    add_csum(8'h00);
    sb.push_back({32'h0, 32'hEFBE_ADDE});
    send_frame(0);
    expect_drained("recover");
    expect_status("recover", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_len_overflow();
    fq = '{8'hA5, 8'h05, 8'h00};
    send_frame(0);
    @(negedge clk);
    expect_status("len_overflow", 1'b0, 1'b1, 1'b1);
    fq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(0);
    expect_drained("len_overflow");
    expect_status("len_overflow_after", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midframe();
    fq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    send_frame(0);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL midreset_mem got we %b addr %h data %h expected 0/0/0", mem_we, mem_addr, mem_wdata);
    end
    expect_status("midreset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    fq = '{8'h33, 8'h44, 8'h02, 8'h00};
    send_frame(0);
    expect_drained("midreset");
    expect_status("midreset_after", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    fq = '{8'hA5, 8'h04, 8'h00};
    for (int i = 0; i < 4; i++) begin
      w = $urandom();
      for (int k = 0; k < 4; k++) fq.push_back(w[8*k +: 8]);
      sb.push_back({32'(4 * i), w});
    end
    add_csum(8'h00);
    send_frame(0);
    expect_drained("back_to_back");
    expect_status("back_to_back", 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_zero_len();
    test_timeout();
    test_len_overflow();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
